// File: rtl/pipe_mismatch_monitor.sv
// Compares the non-blocking and blocking shift-register triplets cycle by cycle,
// flagging disagreements, capturing the first one and counting them.
module pipe_mismatch_monitor #(
    parameter int SETTLE_CYC = 2,
    parameter int CYC_W      = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [2:0]       nb_vec,
    input  logic [2:0]       bk_vec,
    output logic             mismatch,
    output logic             err,
    output logic [CYC_W-1:0] first_cyc,
    output logic [2:0]       first_nb,
    output logic [2:0]       first_bk,
    output logic [CNT_W-1:0] mm_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, ERROR} state_t;

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    // A zero-length settle window skips straight to comparing.
    localparam state_t START_STATE = (SETTLE_CYC == 0) ? COMPARE : SETTLE;

    state_t           state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       nb_q, bk_q;
    logic             mismatch_q, mismatch_d;
    logic             err_q, err_d;
    logic [CYC_W-1:0] first_cyc_q, first_cyc_d;
    logic [2:0]       first_nb_q, first_nb_d;
    logic [2:0]       first_bk_q, first_bk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             diff;

    assign diff = (nb_q != bk_q);

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        cyc_d       = cyc_q;
        mismatch_d  = 1'b0;
        err_d       = err_q;
        first_cyc_d = first_cyc_q;
        first_nb_d  = first_nb_q;
        first_bk_d  = first_bk_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = START_STATE;
                    settle_d = '0;
                    cyc_d    = '0;
                end
            end
            SETTLE: begin
                if (!en) begin
                    state_d  = IDLE;
                    settle_d = '0;
                    cyc_d    = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = COMPARE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            default: begin
                if (!en) begin
                    state_d  = IDLE;
                    settle_d = '0;
                    cyc_d    = '0;
                end else begin
                    mismatch_d = diff;
                    if (cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);
                    if (diff) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                        // Only the very first divergence since reset/clear is recorded.
                        if (!err_q) begin
                            first_cyc_d = cyc_q;
                            first_nb_d  = nb_q;
                            first_bk_d  = bk_q;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            cyc_q       <= '0;
            nb_q        <= '0;
            bk_q        <= '0;
            mismatch_q  <= 1'b0;
            err_q       <= 1'b0;
            first_cyc_q <= '0;
            first_nb_q  <= '0;
            first_bk_q  <= '0;
            cnt_q       <= '0;
        end else if (clr) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            cyc_q       <= '0;
            nb_q        <= '0;
            bk_q        <= '0;
            mismatch_q  <= 1'b0;
            err_q       <= 1'b0;
            first_cyc_q <= '0;
            first_nb_q  <= '0;
            first_bk_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            cyc_q       <= cyc_d;
            nb_q        <= nb_vec;
            bk_q        <= bk_vec;
            mismatch_q  <= mismatch_d;
            err_q       <= err_d;
            first_cyc_q <= first_cyc_d;
            first_nb_q  <= first_nb_d;
            first_bk_q  <= first_bk_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mismatch  = mismatch_q;
    assign err       = err_q;
    assign first_cyc = first_cyc_q;
    assign first_nb  = first_nb_q;
    assign first_bk  = first_bk_q;
    assign mm_cnt    = cnt_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pipe_mismatch_monitor.sv
// Bench for pipe_mismatch_monitor: two parameterisations driven in parallel and
// checked every cycle against a time-since-enable model, plus directed pins.
module tb_pipe_mismatch_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] nb  = 3'b000;
    logic [2:0] bk  = 3'b000;

    logic       a_mm, a_err, a_busy;
    logic [7:0] a_fc;
    logic [2:0] a_fnb, a_fbk;
    logic [3:0] a_cnt;

    logic       b_mm, b_err, b_busy;
    logic [2:0] b_fc;
    logic [2:0] b_fnb, b_fbk;
    logic [7:0] b_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_mismatch_monitor #(.SETTLE_CYC(2), .CYC_W(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .nb_vec(nb), .bk_vec(bk),
        .mismatch(a_mm), .err(a_err), .first_cyc(a_fc), .first_nb(a_fnb),
        .first_bk(a_fbk), .mm_cnt(a_cnt), .busy(a_busy)
    );

    pipe_mismatch_monitor #(.SETTLE_CYC(0), .CYC_W(3), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .nb_vec(nb), .bk_vec(bk),
        .mismatch(b_mm), .err(b_err), .first_cyc(b_fc), .first_nb(b_fnb),
        .first_bk(b_fbk), .mm_cnt(b_cnt), .busy(b_busy)
    );

    typedef struct {
        bit run;
        int age;
        bit mism;
        bit err;
        int first_cyc;
        int first_nb;
        int first_bk;
        int cnt;
        int pnb;
        int pbk;
    } mdl_t;

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.run = 0; z.age = 0; z.mism = 0; z.err = 0;
        z.first_cyc = 0; z.first_nb = 0; z.first_bk = 0; z.cnt = 0;
        z.pnb = 0; z.pbk = 0;
        return z;
    endfunction

    // age = edges already spent enabled; comparisons begin once age reaches the settle length
    task automatic model_step(input mdl_t m, input int s, input int cyc_max, input int cnt_max,
                              input bit r, input bit c, input bit e, input int nbv, input int bkv,
                              output mdl_t o);
        int idx;
        o = m;
        if (r || c) begin
            o = mdl_zero();
            return;
        end
        o.mism = 0;
        if (!e) begin
            o.run = 0;
            o.age = 0;
        end else if (!m.run) begin
            o.run = 1;
            o.age = 0;
        end else begin
            if (m.age >= s) begin
                idx = (m.age - s > cyc_max) ? cyc_max : m.age - s;
                if (m.pnb != m.pbk) begin
                    o.mism = 1;
                    o.cnt  = (m.cnt + 1 > cnt_max) ? cnt_max : m.cnt + 1;
                    if (!m.err) begin
                        o.first_cyc = idx;
                        o.first_nb  = m.pnb;
                        o.first_bk  = m.pbk;
                    end
                    o.err = 1;
                end
            end
            if (m.age < 1000000) o.age = m.age + 1;
        end
        o.pnb = nbv;
        o.pbk = bkv;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    mdl_t ma, mb;

    // Cycle-by-cycle compare of every output of both instances
    initial begin
        ma = mdl_zero();
        mb = mdl_zero();
        forever begin
            @(posedge clk);
            model_step(ma, 2, 255, 15, rst, clr, en, int'(nb), int'(bk), ma);
            model_step(mb, 0, 7, 255, rst, clr, en, int'(nb), int'(bk), mb);
            #1;
            chk("a.mismatch", a_mm, ma.mism);
            chk("a.err", a_err, ma.err);
            chk("a.first_cyc", a_fc, ma.first_cyc);
            chk("a.first_nb", a_fnb, ma.first_nb);
            chk("a.first_bk", a_fbk, ma.first_bk);
            chk("a.mm_cnt", a_cnt, ma.cnt);
            chk("a.busy", a_busy, ma.run);
            chk("b.mismatch", b_mm, mb.mism);
            chk("b.err", b_err, mb.err);
            chk("b.first_cyc", b_fc, mb.first_cyc);
            chk("b.first_nb", b_fnb, mb.first_nb);
            chk("b.first_bk", b_fbk, mb.first_bk);
            chk("b.mm_cnt", b_cnt, mb.cnt);
            chk("b.busy", b_busy, mb.run);
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, " a.mismatch"}, a_mm, 0);
        chk({tag, " a.err"}, a_err, 0);
        chk({tag, " a.first_cyc"}, a_fc, 0);
        chk({tag, " a.first_nb"}, a_fnb, 0);
        chk({tag, " a.first_bk"}, a_fbk, 0);
        chk({tag, " a.mm_cnt"}, a_cnt, 0);
        chk({tag, " a.busy"}, a_busy, 0);
    endtask

    initial begin
        logic [2:0] r3;
        // Reset held with active inputs: everything stays 0
        en = 1'b1; nb = 3'b111; bk = 3'b000;
        for (int i = 0; i < 2; i++) begin
            wait_neg(1);
            chk_zero_a("reset");
            chk("reset b.busy", b_busy, 0);
        end

        // Equal streams for 12 cycles
        rst = 1'b0; nb = 3'b101; bk = 3'b101;
        wait_neg(12);
        chk("equal a.err", a_err, 0);
        chk("equal a.mm_cnt", a_cnt, 0);
        chk("equal a.busy", a_busy, 1);
        chk("equal b.err", b_err, 0);

        // Single divergence landing on compare index 3 of the settled instance
        en = 1'b0;
        wait_neg(1);
        en = 1'b1;
        wait_neg(5);
        nb = 3'b111; bk = 3'b011;
        wait_neg(1);
        nb = 3'b101; bk = 3'b101;
        wait_neg(2);
        chk("first a.err", a_err, 1);
        chk("first a.mm_cnt", a_cnt, 1);
        chk("first a.first_cyc", a_fc, 3);
        chk("first a.first_nb", a_fnb, 3'b111);
        chk("first a.first_bk", a_fbk, 3'b011);
        chk("first b.first_cyc", b_fc, 5);

        // Long mismatch burst saturates the 4-bit counter
        for (int i = 0; i < 21; i++) begin
            r3 = 3'($urandom);
            nb = r3; bk = ~r3;
            wait_neg(1);
        end
        chk("sat a.mm_cnt", a_cnt, 15);
        chk("sat a.err", a_err, 1);

        // clr on an edge that also carries a mismatching compare
        clr = 1'b1;
        wait_neg(1);
        chk_zero_a("clr");
        clr = 1'b0;
        wait_neg(1);
        chk("reenable a.busy", a_busy, 1);
        chk("reenable a.mismatch", a_mm, 0);

        // Reach ERROR again, then assert rst between edges
        wait_neg(6);
        chk("pre-rst a.err", a_err, 1);
        #2 rst = 1'b1;
        #1;
        chk_zero_a("async-rst");
        chk("async-rst b.err", b_err, 0);
        chk("async-rst b.mm_cnt", b_cnt, 0);
        wait_neg(2);
        rst = 1'b0; en = 1'b0;
        wait_neg(3);
        chk("post-rst a.busy", a_busy, 0);
        en = 1'b1; nb = 3'b000; bk = 3'b000;
        wait_neg(1);
        chk("post-rst en a.busy", a_busy, 1);

        // Randomised traffic with occasional enable drops, clears and resets
        for (int i = 0; i < 3000; i++) begin
            r3 = 3'($urandom);
            nb = r3;
            bk = ($urandom_range(0, 9) < 8) ? r3 : 3'($urandom);
            if ($urandom_range(0, 19) == 0) en = ~en;
            clr = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 299) == 0);
            wait_neg(1);
        end
        rst = 1'b0; clr = 1'b0;
        wait_neg(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
